// File: rtl/gate_check_pkg.sv
// Shared types and truth tables for the NAND/NOR gate self-test sequencer.
package gate_check_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  // Indexed by vec = {a,b}
  localparam logic [3:0] EXP_NAND = 4'b0111;
  localparam logic [3:0] EXP_NOR  = 4'b0001;

  function automatic logic [1:0] mismatch_mask(input logic [1:0] vec,
                                               input logic       nand_v,
                                               input logic       nor_v);
    return {nor_v != EXP_NOR[vec], nand_v != EXP_NAND[vec]};
  endfunction

endpackage

// File: rtl/gate_check_settle_timer.sv
// Loadable down-counter; tc is high once the count has reached zero.
module gate_check_settle_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/gate_sweep_checker.sv
// Drives the gate block through all four {a,b} vectors, checks nand/nor
// against the truth tables and reports a saturating error count and first failure.
module gate_sweep_checker
  import gate_check_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int LOOPS         = 1,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             nand_in,
  input  logic             nor_in,
  output logic             a_out,
  output logic             b_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [1:0]       first_fail_vec,
  output logic [1:0]       first_fail_mask
);

  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0]       LAST_LOOP   = 8'(LOOPS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  state_t           state;
  logic [1:0]       vec;
  logic [7:0]       loop_cnt;
  logic             settle_load;
  logic             settle_tc;
  logic             last_vec;
  logic [1:0]       mask;
  logic [1:0]       n_mis;
  logic [ERR_W-1:0] err_next;

  function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] acc,
                                               input logic [1:0]       inc);
    logic [ERR_W:0] sum;
    sum = {1'b0, acc} + (ERR_W+1)'(inc);
    return (sum > {1'b0, ERR_MAX}) ? ERR_MAX : sum[ERR_W-1:0];
  endfunction

  assign mask        = mismatch_mask(vec, nand_in, nor_in);
  assign n_mis       = {1'b0, mask[0]} + {1'b0, mask[1]};
  assign err_next    = sat_add(err_count, n_mis);
  assign last_vec    = (vec == 2'd3) && (loop_cnt >= LAST_LOOP);
  assign settle_load = ((state == IDLE) && start) || ((state == SAMPLE) && !last_vec);

  gate_check_settle_timer #(.CNT_W(4)) u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (settle_load),
    .load_val (SETTLE_LOAD),
    .en       (state == DRIVE),
    .tc       (settle_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      vec             <= '0;
      loop_cnt        <= '0;
      a_out           <= 1'b0;
      b_out           <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      fail_valid      <= 1'b0;
      first_fail_vec  <= '0;
      first_fail_mask <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            err_count       <= '0;
            fail_valid      <= 1'b0;
            first_fail_vec  <= '0;
            first_fail_mask <= '0;
            pass            <= 1'b0;
            vec             <= '0;
            loop_cnt        <= '0;
            {a_out, b_out}  <= 2'b00;
            busy            <= 1'b1;
            state           <= DRIVE;
          end
        end
        DRIVE: begin
          if (settle_tc) state <= SAMPLE;
        end
        SAMPLE: begin
          err_count <= err_next;
          if (!fail_valid && mask != 2'b00) begin
            fail_valid      <= 1'b1;
            first_fail_vec  <= vec;
            first_fail_mask <= mask;
          end
          // Stimulus moves on the same edge so the next DRIVE already shows it
          if (vec != 2'd3) begin
            vec            <= vec + 2'd1;
            {a_out, b_out} <= vec + 2'd1;
            state          <= DRIVE;
          end else if (!last_vec) begin
            vec            <= '0;
            loop_cnt       <= loop_cnt + 8'd1;
            {a_out, b_out} <= 2'b00;
            state          <= DRIVE;
          end else begin
            {a_out, b_out} <= 2'b00;
            busy           <= 1'b0;
            done           <= 1'b1;
            pass           <= (err_next == '0);
            state          <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
